// File: rtl/vending_controller_param.sv
// vending_controller_param: vending FSM with coin validation, per-drink price/stock tables, inactivity timeout and greedy change
// Inputs : coin_valid/coin (acceptor), drink_sel/cancel (keypad), restock_valid/restock_id/restock_qty (service port)
// Outputs: total_money/state (status), drink_out/drink_valid (dispenser), change_coin/change_valid/change_done (hopper),
//          coin_reject/sel_reject (one-cycle refusals), sold_out (bit k-1 set when drink k is empty)
module vending_controller_param #(
  parameter int MONEY_W = 8,
  parameter int N_DRINKS = 4,
  parameter int SEL_W = 3,
  parameter logic [N_DRINKS*MONEY_W-1:0] PRICES = {8'd25, 8'd20, 8'd15, 8'd10},
  parameter int STOCK_W = 4,
  parameter int INIT_STOCK = 4,
  parameter int MAX_CREDIT = 200,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [MONEY_W-1:0]  coin,
  input  logic [SEL_W-1:0]    drink_sel,
  input  logic                cancel,
  input  logic                restock_valid,
  input  logic [SEL_W-1:0]    restock_id,
  input  logic [STOCK_W-1:0]  restock_qty,
  output logic [MONEY_W-1:0]  total_money,
  output logic [2:0]          state,
  output logic [SEL_W-1:0]    drink_out,
  output logic                drink_valid,
  output logic [MONEY_W-1:0]  change_coin,
  output logic                change_valid,
  output logic                change_done,
  output logic                coin_reject,
  output logic                sel_reject,
  output logic [N_DRINKS-1:0] sold_out
);
  typedef enum logic [2:0] {IDLE = 3'd0, CREDIT = 3'd1, VEND = 3'd2, CHANGE = 3'd3} state_t;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  state_t              state_q;
  logic [MONEY_W-1:0]  total_q, change_coin_q, price, change;
  logic [SEL_W-1:0]    drink_out_q;
  logic                drink_valid_q, change_valid_q, change_done_q, coin_reject_q, sel_reject_q;
  logic [N_DRINKS-1:0] sold_out_q;
  logic [STOCK_W-1:0]  stock_q [N_DRINKS];
  logic [STOCK_W-1:0]  stock_d [N_DRINKS];
  logic [STOCK_W-1:0]  sel_stock, base;
  logic [STOCK_W:0]    radd;
  logic [MONEY_W:0]    coin_sum;
  logic [CNT_W-1:0]    cnt_q;
  logic                coin_legal, coin_ok, decide, vend_ok, sel_rej, timeout;
  always_comb begin
    coin_legal = coin == MONEY_W'(1) || coin == MONEY_W'(5) || coin == MONEY_W'(10) || coin == MONEY_W'(50);
    coin_sum = {1'b0, total_q} + {1'b0, coin};
    // cancel outranks a coin in CREDIT, so a coin arriving with cancel is handed back
    coin_ok = coin_valid && coin_legal && coin_sum <= (MONEY_W+1)'(MAX_CREDIT) &&
              (state_q == IDLE || (state_q == CREDIT && !cancel));
    price = '0;
    sel_stock = '0;
    for (int k = 0; k < N_DRINKS; k++) begin
      if (drink_sel == SEL_W'(k + 1)) begin
        price = PRICES[k*MONEY_W +: MONEY_W];
        sel_stock = stock_q[k];
      end
    end
    decide = state_q == CREDIT && !cancel && !coin_ok;
    vend_ok = decide && drink_sel != '0 && drink_sel <= SEL_W'(N_DRINKS) && price <= total_q && sel_stock != '0;
    sel_rej = decide && drink_sel != '0 && !vend_ok;
    timeout = decide && drink_sel == '0 && cnt_q >= CNT_W'(TIMEOUT_CYC - 1);
    change = total_q >= MONEY_W'(50) ? MONEY_W'(50) : total_q >= MONEY_W'(10) ? MONEY_W'(10) :
             total_q >= MONEY_W'(5) ? MONEY_W'(5) : MONEY_W'(1);
    base = '0;
    radd = '0;
    // vend decrement is applied first so a same-cycle restock saturates the net value
    for (int k = 0; k < N_DRINKS; k++) begin
      base = stock_q[k] - STOCK_W'(vend_ok && drink_sel == SEL_W'(k + 1));
      radd = {1'b0, base} + {1'b0, restock_qty};
      stock_d[k] = restock_valid && restock_id == SEL_W'(k + 1) ? (radd[STOCK_W] ? '1 : radd[STOCK_W-1:0]) : base;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      total_q <= '0;
      cnt_q <= '0;
      drink_out_q <= '0;
      drink_valid_q <= 1'b0;
      change_coin_q <= '0;
      change_valid_q <= 1'b0;
      change_done_q <= 1'b0;
      coin_reject_q <= 1'b0;
      sel_reject_q <= 1'b0;
      for (int k = 0; k < N_DRINKS; k++) stock_q[k] <= STOCK_W'(INIT_STOCK);
      sold_out_q <= {N_DRINKS{INIT_STOCK == 0}};
    end else begin
      drink_out_q <= '0;
      drink_valid_q <= 1'b0;
      change_coin_q <= '0;
      change_valid_q <= 1'b0;
      change_done_q <= 1'b0;
      coin_reject_q <= coin_valid && !coin_ok;
      sel_reject_q <= sel_rej;
      for (int k = 0; k < N_DRINKS; k++) begin
        stock_q[k] <= stock_d[k];
        sold_out_q[k] <= stock_d[k] == '0;
      end
      if (coin_ok) begin
        total_q <= coin_sum[MONEY_W-1:0];
        cnt_q <= '0;
      end else if (state_q == CREDIT && cnt_q < CNT_W'(TIMEOUT_CYC - 1)) cnt_q <= cnt_q + CNT_W'(1);
      case (state_q)
        IDLE: if (coin_ok) state_q <= CREDIT;
        CREDIT: begin
          if (cancel || timeout) state_q <= CHANGE;
          else if (vend_ok) begin
            state_q <= VEND;
            drink_valid_q <= 1'b1;
            drink_out_q <= drink_sel;
            total_q <= total_q - price;
          end
        end
        VEND: state_q <= CHANGE;
        CHANGE: begin
          if (total_q != '0) begin
            change_valid_q <= 1'b1;
            change_coin_q <= change;
            total_q <= total_q - change;
          end else begin
            change_done_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign total_money = total_q;
  assign state = state_q;
  assign drink_out = drink_out_q;
  assign drink_valid = drink_valid_q;
  assign change_coin = change_coin_q;
  assign change_valid = change_valid_q;
  assign change_done = change_done_q;
  assign coin_reject = coin_reject_q;
  assign sel_reject = sel_reject_q;
  assign sold_out = sold_out_q;
endmodule

// File: tb/tb_vending_controller_param.sv
// tb_vending_controller_param: directed scenarios plus randomized traffic against a rule-level reference model
module tb_vending_controller_param;
  logic clk = 0, reset = 1, coin_valid = 0, cancel = 0, restock_valid = 0;
  logic [7:0] coin = 0;
  logic [2:0] drink_sel = 0, restock_id = 0;
  logic [3:0] restock_qty = 0;
  logic [7:0] total_money, change_coin;
  logic [2:0] state, drink_out;
  logic drink_valid, change_valid, change_done, coin_reject, sel_reject;
  logic [3:0] sold_out;
  int checks = 0, failures = 0;
  int m_st, m_tot, m_idle, e_do, e_cc;
  int m_stock[4];
  bit e_dv, e_cv, e_cd, e_cr, e_sr;
  int prices[4] = '{10, 15, 20, 25};

  vending_controller_param dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin(coin), .drink_sel(drink_sel), .cancel(cancel),
    .restock_valid(restock_valid), .restock_id(restock_id), .restock_qty(restock_qty),
    .total_money(total_money), .state(state), .drink_out(drink_out), .drink_valid(drink_valid),
    .change_coin(change_coin), .change_valid(change_valid), .change_done(change_done),
    .coin_reject(coin_reject), .sel_reject(sel_reject), .sold_out(sold_out)
  );

  always #5 clk = ~clk;

  // Reference: applies the machine's rules to the inputs presented at the coming edge
  task automatic model_step();
    bit took;
    int s, c;
    e_dv = 0; e_do = 0; e_cv = 0; e_cc = 0; e_cd = 0; e_cr = 0; e_sr = 0;
    if (reset) begin
      m_st = 0; m_tot = 0; m_idle = 0;
      foreach (m_stock[k]) m_stock[k] = 4;
      return;
    end
    c = int'(coin);
    s = int'(drink_sel);
    took = coin_valid && (m_st == 0 || (m_st == 1 && !cancel)) && (c == 1 || c == 5 || c == 10 || c == 50) && m_tot + c <= 200;
    e_cr = coin_valid && !took;
    if (m_st == 0) begin
      if (took) begin m_tot += c; m_st = 1; m_idle = 0; end
    end else if (m_st == 1) begin
      if (cancel) m_st = 3;
      else if (took) begin m_tot += c; m_idle = 0; end
      else if (s >= 1 && s <= 4 && prices[s-1] <= m_tot && m_stock[s-1] > 0) begin
        m_st = 2; e_dv = 1; e_do = s; m_tot -= prices[s-1]; m_stock[s-1]--;
      end else if (s != 0) begin e_sr = 1; m_idle++; end
      else if (m_idle >= 999) m_st = 3;
      else m_idle++;
    end else if (m_st == 2) m_st = 3;
    else begin
      if (m_tot > 0) begin
        e_cc = m_tot >= 50 ? 50 : m_tot >= 10 ? 10 : m_tot >= 5 ? 5 : 1;
        e_cv = 1; m_tot -= e_cc;
      end else begin e_cd = 1; m_st = 0; end
    end
    if (restock_valid && restock_id >= 1 && restock_id <= 4)
      m_stock[restock_id-1] = m_stock[restock_id-1] + int'(restock_qty) > 15 ? 15 : m_stock[restock_id-1] + int'(restock_qty);
  endtask

  function automatic logic [30:0] model_vec();
    logic [3:0] so;
    for (int k = 0; k < 4; k++) so[k] = m_stock[k] == 0;
    return {3'(m_st), 8'(m_tot), 3'(e_do), e_dv, 8'(e_cc), e_cv, e_cd, e_cr, e_sr, so};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(input int v);
    coin_valid = 1; coin = 8'(v); tick(); coin_valid = 0; coin = 0;
  endtask

  task automatic select(input int s);
    drink_sel = 3'(s); tick(); drink_sel = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && state != 3'd0; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1; tick(); tick(); reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", state); end
    checks++; if (total_money !== 8'd0) begin failures++; $display("FAIL reset_total got=%0d want=0", total_money); end
    checks++; if ({drink_valid, change_valid, change_done, coin_reject, sel_reject} !== 5'b0) begin failures++; $display("FAIL reset_pulses got=%b want=00000", {drink_valid, change_valid, change_done, coin_reject, sel_reject}); end
    checks++; if (sold_out !== 4'b0) begin failures++; $display("FAIL reset_sold_out got=%b want=0000", sold_out); end
  endtask

  task automatic test_vend_exact();
    put_coin(10); put_coin(5);
    checks++; if ({state, total_money} !== {3'd1, 8'd15}) begin failures++; $display("FAIL credit15 got state=%0d total=%0d want 1/15", state, total_money); end
    select(2);
    checks++; if ({state, drink_valid, drink_out, total_money} !== {3'd2, 1'b1, 3'd2, 8'd0}) begin failures++; $display("FAIL vend2 got state=%0d dv=%0d id=%0d total=%0d want 2/1/2/0", state, drink_valid, drink_out, total_money); end
    tick();
    checks++; if ({state, drink_valid} !== {3'd3, 1'b0}) begin failures++; $display("FAIL vend_to_change got state=%0d dv=%0d want 3/0", state, drink_valid); end
    tick();
    checks++; if ({state, change_done, change_valid} !== {3'd0, 1'b1, 1'b0}) begin failures++; $display("FAIL exact_done got state=%0d done=%0d cv=%0d want 0/1/0", state, change_done, change_valid); end
  endtask

  task automatic test_change();
    put_coin(50); put_coin(10); select(1);
    checks++; if ({state, drink_out, total_money} !== {3'd2, 3'd1, 8'd50}) begin failures++; $display("FAIL vend1 got state=%0d id=%0d total=%0d want 2/1/50", state, drink_out, total_money); end
    tick(); tick();
    checks++; if ({change_valid, change_coin, total_money} !== {1'b1, 8'd50, 8'd0}) begin failures++; $display("FAIL change50 got cv=%0d coin=%0d total=%0d want 1/50/0", change_valid, change_coin, total_money); end
    tick();
    checks++; if ({state, change_done, change_valid} !== {3'd0, 1'b1, 1'b0}) begin failures++; $display("FAIL change50_done got state=%0d done=%0d cv=%0d want 0/1/0", state, change_done, change_valid); end
  endtask

  task automatic test_coin_reject();
    put_coin(3);
    checks++; if ({coin_reject, total_money, state} !== {1'b1, 8'd0, 3'd0}) begin failures++; $display("FAIL coin3 got rej=%0d total=%0d state=%0d want 1/0/0", coin_reject, total_money, state); end
    for (int i = 0; i < 3; i++) put_coin(50);
    for (int i = 0; i < 4; i++) put_coin(10);
    checks++; if (total_money !== 8'd190) begin failures++; $display("FAIL credit190 got=%0d want=190", total_money); end
    put_coin(50);
    checks++; if ({coin_reject, total_money} !== {1'b1, 8'd190}) begin failures++; $display("FAIL ceiling got rej=%0d total=%0d want 1/190", coin_reject, total_money); end
    put_coin(10);
    checks++; if ({coin_reject, total_money} !== {1'b0, 8'd200}) begin failures++; $display("FAIL credit200 got rej=%0d total=%0d want 0/200", coin_reject, total_money); end
    cancel = 1; tick(); cancel = 0; drain();
    checks++; if ({state, total_money} !== {3'd0, 8'd0}) begin failures++; $display("FAIL refund200 got state=%0d total=%0d want 0/0", state, total_money); end
  endtask

  task automatic test_sel_reject_cancel();
    put_coin(10); select(4);
    checks++; if ({sel_reject, state, total_money} !== {1'b1, 3'd1, 8'd10}) begin failures++; $display("FAIL sel_poor got rej=%0d state=%0d total=%0d want 1/1/10", sel_reject, state, total_money); end
    select(6);
    checks++; if (sel_reject !== 1'b1) begin failures++; $display("FAIL sel_range got=%0d want=1", sel_reject); end
    cancel = 1; tick(); cancel = 0; tick();
    checks++; if ({change_valid, change_coin} !== {1'b1, 8'd10}) begin failures++; $display("FAIL cancel_coin got cv=%0d coin=%0d want 1/10", change_valid, change_coin); end
    tick();
    checks++; if ({state, change_done} !== {3'd0, 1'b1}) begin failures++; $display("FAIL cancel_done got state=%0d done=%0d want 0/1", state, change_done); end
    select(1);
    checks++; if (sel_reject !== 1'b0) begin failures++; $display("FAIL idle_sel got=%0d want=0", sel_reject); end
  endtask

  task automatic test_sold_out();
    do_reset();
    for (int i = 0; i < 4; i++) begin put_coin(10); select(1); drain(); end
    checks++; if (sold_out !== 4'b0001) begin failures++; $display("FAIL sold_out1 got=%b want=0001", sold_out); end
    put_coin(10); select(1);
    checks++; if ({sel_reject, state} !== {1'b1, 3'd1}) begin failures++; $display("FAIL sold_sel got rej=%0d state=%0d want 1/1", sel_reject, state); end
    cancel = 1; tick(); cancel = 0; drain();
    restock_valid = 1; restock_id = 1; restock_qty = 15; tick();
    restock_qty = 3; tick(); restock_valid = 0;
    checks++; if (sold_out !== 4'b0000) begin failures++; $display("FAIL restock got=%b want=0000", sold_out); end
    for (int i = 0; i < 14; i++) begin put_coin(10); select(1); drain(); end
    checks++; if (sold_out !== 4'b0000) begin failures++; $display("FAIL saturate14 got=%b want=0000", sold_out); end
    put_coin(10); select(1); drain();
    checks++; if (sold_out !== 4'b0001) begin failures++; $display("FAIL saturate15 got=%b want=0001", sold_out); end
  endtask

  task automatic test_timeout();
    int exp_coins[5] = '{10, 10, 5, 1, 1};
    do_reset();
    put_coin(10); put_coin(10); put_coin(5); put_coin(1); put_coin(1);
    for (int i = 0; i < 999; i++) tick();
    checks++; if ({state, total_money} !== {3'd1, 8'd27}) begin failures++; $display("FAIL pre_timeout got state=%0d total=%0d want 1/27", state, total_money); end
    tick();
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL timeout got state=%0d want=3", state); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if ({change_valid, change_coin} !== {1'b1, 8'(exp_coins[i])}) begin failures++; $display("FAIL timeout_coin%0d got cv=%0d coin=%0d want 1/%0d", i, change_valid, change_coin, exp_coins[i]); end
    end
    tick();
    checks++; if ({state, change_done, change_valid, total_money} !== {3'd0, 1'b1, 1'b0, 8'd0}) begin failures++; $display("FAIL timeout_done got state=%0d done=%0d cv=%0d total=%0d want 0/1/0/0", state, change_done, change_valid, total_money); end
  endtask

  task automatic test_reset_mid_change();
    put_coin(10); put_coin(10); put_coin(5); put_coin(1); put_coin(1);
    cancel = 1; tick(); cancel = 0; tick();
    reset = 1; tick();
    checks++; if ({state, total_money, change_valid} !== {3'd0, 8'd0, 1'b0}) begin failures++; $display("FAIL mid_reset got state=%0d total=%0d cv=%0d want 0/0/0", state, total_money, change_valid); end
    reset = 0; tick();
    checks++; if ({state, change_valid, change_done} !== {3'd0, 1'b0, 1'b0}) begin failures++; $display("FAIL post_reset got state=%0d cv=%0d done=%0d want 0/0/0", state, change_valid, change_done); end
  endtask

  task automatic test_random();
    int opts[8] = '{1, 5, 10, 50, 3, 20, 0, 25};
    logic [30:0] got, want;
    int shown = 0;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      coin_valid = $urandom_range(0, 9) < 4;
      coin = 8'(opts[$urandom_range(0, 7)]);
      cancel = !coin_valid && $urandom_range(0, 19) == 0;
      drink_sel = $urandom_range(0, 9) < 3 ? 3'($urandom_range(1, 7)) : 3'd0;
      restock_valid = $urandom_range(0, 19) == 0;
      restock_id = 3'($urandom_range(0, 7));
      restock_qty = 4'($urandom_range(0, 15));
      tick();
      got = {state, total_money, drink_out, drink_valid, change_coin, change_valid, change_done, coin_reject, sel_reject, sold_out};
      want = model_vec();
      checks++;
      if (got !== want) begin
        failures++;
        if (shown++ < 10) $display("FAIL random_cycle%0d got=%h want=%h", i, got, want);
      end
    end
    coin_valid = 0; cancel = 0; drink_sel = 0; restock_valid = 0;
  endtask

  initial begin
    test_reset();
    test_vend_exact();
    test_change();
    test_coin_reject();
    test_sel_reject_cancel();
    test_sold_out();
    test_timeout();
    test_reset_mid_change();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vending_controller_param.md
Name: vending_controller_param

Overview:
Parametrised next-generation vending controller: N drinks with a per-drink price table and per-drink stock counters. Adds coin validation with credit ceiling, cancel/refund, inactivity timeout, and coin-by-coin change dispensing. Sits between the coin acceptor/keypad front end and the dispense/change-hopper actuators.

Parameters:
MONEY_W, 8, width of coin, credit and change values
N_DRINKS, 4, number of selectable drinks (1..7)
SEL_W, 3, drink-select/drink-out width; 0 = none
PRICES, {8'd25,8'd20,8'd15,8'd10}, packed N_DRINKS*MONEY_W price table; drink k uses slice k-1
STOCK_W, 4, per-drink stock counter width
INIT_STOCK, 4, stock value loaded at reset
MAX_CREDIT, 200, credit ceiling
TIMEOUT_CYC, 1000, idle cycles in CREDIT before auto-refund

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
coin_valid  input  1  coin present this cycle
coin  input  MONEY_W  coin value
drink_sel  input  SEL_W  drink request, 0 = none
cancel  input  1  refund request
restock_valid  input  1  restock strobe
restock_id  input  SEL_W  drink to restock (1..N_DRINKS)
restock_qty  input  STOCK_W  units added
total_money  output  MONEY_W  current credit / remaining change
state  output  3  0 IDLE, 1 CREDIT, 2 VEND, 3 CHANGE
drink_out  output  SEL_W  dispensed drink id, 0 otherwise
drink_valid  output  1  one-cycle dispense pulse
change_coin  output  MONEY_W  coin released this cycle
change_valid  output  1  change_coin is valid
change_done  output  1  one-cycle end-of-transaction pulse
coin_reject  output  1  one-cycle pulse: coin returned
sel_reject  output  1  one-cycle pulse: selection refused
sold_out  output  N_DRINKS  bit k-1 high when drink k stock == 0

Behaviour:
- All outputs are registered and update on the same edge as state.
- Reset (synchronous, active-high): state=IDLE, total_money=0, every pulse output=0, drink_out=0, change_coin=0, all stocks=INIT_STOCK, timeout counter=0. Reset mid-transaction discards credit; no refund is emitted.
- Coin acceptance happens only in IDLE/CREDIT with coin_valid=1. The coin must be one of 1, 5, 10, 50, and total+coin must be <= MAX_CREDIT. An accepted coin adds to total_money next cycle. Otherwise coin_reject pulses next cycle and total is unchanged. A coin offered in VEND/CHANGE is always rejected.
- IDLE: an accepted coin moves to CREDIT.
- CREDIT, evaluated in priority order:
  1. cancel: go to CHANGE.
  2. Accepted coin: add coin, any drink_sel is ignored, timeout counter cleared.
  3. drink_sel in 1..N_DRINKS with price <= total and stock > 0: go to VEND.
  4. drink_sel nonzero otherwise (out of range, insufficient credit, sold out): sel_reject pulses, stay in CREDIT.
  5. Timeout counter reaching TIMEOUT_CYC-1 with no accepted coin: go to CHANGE.
- VEND (exactly 1 cycle): drink_valid=1, drink_out=id, stock[id] decremented, total_money=total-price. Next state is CHANGE.
- CHANGE: each cycle, while total>0, output the largest of {50,10,5,1} that is <= total on change_coin with change_valid=1, and subtract it from total. In the cycle total is 0 (including on entry), assert change_done=1 with change_valid=0 and go to IDLE next.
- Change latency: the refund of credit C takes greedy_coin_count(C)+1 cycles in CHANGE.
- cancel and drink_sel are ignored outside CREDIT; drink_sel is ignored in IDLE (no sel_reject).
- Restock is accepted in any state. stock[id] = min(stock+qty, 2^STOCK_W-1). If it coincides with a VEND of the same id, the net result is min(stock-1+qty, max). restock_id of 0 or > N_DRINKS is ignored.
- sold_out reflects the registered stock values.
- Arithmetic: all credit maths is MONEY_W unsigned. No wrap is possible, because MAX_CREDIT < 2^MONEY_W and the range is checked before add/subtract.
- Unused state encodings recover to IDLE.

Test Plan:
- Reset, then coins 10,5 then drink_sel=2 (price 15) -> VEND with drink_out=2 and drink_valid pulse, then change_done with no change_valid, stock[2]=3, back in IDLE.
- Coins 50,10, drink_sel=1 (price 10) -> change_coin sequence 50 on consecutive cycles, then change_done, total_money=0.
- Coin 3 -> coin_reject pulse, total stays 0. Credit 190 plus coin 50 -> rejected, total stays 190.
- Credit 10, drink_sel=4 -> sel_reject pulse. Then cancel -> change_coin 10, change_done, state IDLE.
- Drink 1 vended 4 times -> sold_out[0]=1 and a fifth request gives sel_reject. Restock id=1 qty=15 with stock 0 -> stock=15. Restock qty 3 with stock 15 -> saturates at 15.
- Credit 27 and no activity for TIMEOUT_CYC cycles -> change_coin 10, 10, 5, 1, 1, then change_done. Assert reset mid-CHANGE -> next cycle IDLE, total_money=0, no further change_valid.
